// File: rtl/pe_link_arbiter_if.sv
// Handshake bundle for pe_link_arbiter: four requester ports, one shared
// output link and the grant vector. Optional beat_cnt: PE_ARB_BEAT_CNT_EN.
// Signals:
//   ap_start  : run enable.
//   in_data   : four payloads, port i at [i*DATA_WIDTH +: DATA_WIDTH].
//   in_valid  : per-port beat valid.
//   in_last   : per-port last-beat flag.
//   in_ready  : per-port beat accept.
//   out_data  : shared-link payload.
//   out_valid : shared-link beat valid.
//   out_last  : shared-link last flag.
//   out_ready : downstream accept.
//   grant     : one-hot link owner.
//   beat_cnt  : per-port accepted-beat counts (optional).
interface pe_link_arbiter_if #(
    parameter int DATA_WIDTH = 130,
    parameter int CNT_WIDTH  = 32
);
    logic                    ap_start;
    logic [4*DATA_WIDTH-1:0] in_data;
    logic [3:0]              in_valid;
    logic [3:0]              in_last;
    logic [3:0]              in_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic [3:0]              grant;
`ifdef PE_ARB_BEAT_CNT_EN
    logic [4*CNT_WIDTH-1:0]  beat_cnt;
`endif

    modport master (
        output ap_start,
        output in_data,
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_last,
`ifdef PE_ARB_BEAT_CNT_EN
        input  beat_cnt,
`endif
        input  grant
    );

    modport slave (
        input  ap_start,
        input  in_data,
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_last,
`ifdef PE_ARB_BEAT_CNT_EN
        output beat_cnt,
`endif
        output grant
    );
endinterface

// File: rtl/pe_link_arbiter.sv
// Four-port packet-locked round-robin arbiter onto one registered link.
// Ports: clk, reset (async, active high), bus (pe_link_arbiter_if.slave).
// Optional per-port beat counters: define PE_ARB_BEAT_CNT_EN.
module pe_link_arbiter #(
    parameter int DATA_WIDTH = 130,
    parameter int CNT_WIDTH  = 32
) (
    input logic               clk,
    input logic               reset,
    pe_link_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            grant_q, grant_d;
    logic [1:0]            owner_q, owner_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d;
    logic                  ovalid_q, ovalid_d;
    logic                  olast_q, olast_d;

    logic [1:0]            gidx;
    logic [1:0]            win;
    logic                  win_vld;
    logic [1:0]            scan;
    logic [3:0]            rdy;
    logic                  acc;
    logic                  beat_last;

    // Index of the current owner; grant_q is one-hot in LOCKED.
    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) gidx = 2'(i);
        end
    end

    // Scan from farthest to nearest so the port right after the
    // previous owner overrides everything else.
    always_comb begin
        win     = owner_q;
        win_vld = 1'b0;
        scan    = owner_q;
        for (int k = 4; k >= 1; k--) begin
            scan = owner_q + 2'(k);
            if (bus.in_valid[scan]) begin
                win     = scan;
                win_vld = 1'b1;
            end
        end
    end

    assign rdy = (state_q == LOCKED)
               ? grant_q & {4{bus.ap_start & (~ovalid_q | bus.out_ready)}}
               : 4'b0000;

    assign acc       = |(bus.in_valid & rdy);
    assign beat_last = bus.in_last[gidx];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ap_start && win_vld) begin
                    state_d = LOCKED;
                    grant_d = 4'b0001 << win;
                end
            end
            LOCKED: begin
                if (acc && beat_last) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    owner_d = gidx;
                end
            end
        endcase
    end

    // Output register: accept refills it, drain alone empties it.
    always_comb begin
        odata_d  = odata_q;
        olast_d  = olast_q;
        ovalid_d = ovalid_q;
        if (acc) begin
            odata_d  = bus.in_data[gidx*DATA_WIDTH +: DATA_WIDTH];
            olast_d  = beat_last;
            ovalid_d = 1'b1;
        end else if (bus.out_ready) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            owner_q  <= 2'd3;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = odata_q;
    assign bus.out_valid = ovalid_q;
    assign bus.out_last  = olast_q;
    assign bus.grant     = grant_q;

`ifdef PE_ARB_BEAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.in_valid[i] && rdy[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        bus.beat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            bus.beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_pe_link_arbiter.sv
// Scoreboard bench for pe_link_arbiter: directed packets per port,
// expected beats/grants queued, negedge monitor pops and compares.
module tb_pe_link_arbiter;

    localparam int DW = 130;
`ifdef PE_ARB_BEAT_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [3:0]    gap;
    } beat_t;

    logic clk;
    logic reset;

    pe_link_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    pe_link_arbiter #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    beat_t         pq [4][$];
    beat_t         exq[$];
    logic [3:0]    gexp[$];
    beat_t         drv_b;
    beat_t         mon_b;
    logic [3:0]    acc;
    logic [3:0]    er;
    logic [3:0]    prev_g;
    logic          prev_ap, prev_ov, prev_or, prev_l;
    logic [DW-1:0] prev_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int p, int d, logic l, int gap);
        beat_t b;
        b.d   = DW'(d);
        b.l   = l;
        b.gap = 4'(gap);
        pq[p].push_back(b);
    endtask

    task automatic expb(int d, logic l);
        beat_t b;
        b.d   = DW'(d);
        b.l   = l;
        b.gap = 4'd0;
        exq.push_back(b);
    endtask

    function automatic bit busy();
        return exq.size() != 0 || gexp.size() != 0 ||
               pq[0].size() != 0 || pq[1].size() != 0 ||
               pq[2].size() != 0 || pq[3].size() != 0;
    endfunction

    task automatic drain(string nm);
        int n = 0;
        while (busy() && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL drain_%s: got pending=%0d want 0", nm, exq.size());
        end
        tick();
        tick();
    endtask

    task automatic wait_ov(string nm);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_ov_%s: got out_valid=0 want 1", nm);
        end
    endtask

    task automatic wait_grant(logic [3:0] g);
        int n = 0;
        while (bus.grant !== g && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait_grant: got %b want %b", bus.grant, g);
        end
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_grant"}, DW'(bus.grant), '0);
        chk({nm, "_in_ready"}, DW'(bus.in_ready), '0);
        chk({nm, "_out_valid"}, DW'(bus.out_valid), '0);
        chk({nm, "_out_last"}, DW'(bus.out_last), '0);
        chk({nm, "_out_data"}, bus.out_data, '0);
`ifdef PE_ARB_BEAT_CNT_EN
        chk({nm, "_beat_cnt"}, DW'(bus.beat_cnt), '0);
`endif
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) pq[i].delete();
        exq.delete();
        gexp.delete();
    endtask

    // Requester driver: pops a beat when it was accepted at the last edge.
    initial begin
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
        acc          = '0;
        forever begin
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() == 0) begin
                    bus.in_valid[i] = 1'b0;
                    bus.in_last[i]  = 1'b0;
                end else if (pq[i][0].gap != 4'd0) begin
                    drv_b       = pq[i][0];
                    drv_b.gap   = drv_b.gap - 4'd1;
                    pq[i][0]    = drv_b;
                    bus.in_valid[i] = 1'b0;
                end else begin
                    bus.in_valid[i] = 1'b1;
                    bus.in_last[i]  = pq[i][0].l;
                    bus.in_data[i*DW +: DW] = pq[i][0].d;
                end
            end
        end
    end

    // Monitor: link beats, grant order and handshake rules.
    always @(negedge clk) begin
        if (reset) begin
            prev_g  = '0;
            prev_ap = 1'b1;
            prev_ov = 1'b0;
            prev_or = 1'b1;
            prev_l  = 1'b0;
            prev_d  = '0;
        end else begin
            er = bus.grant &
                 {4{bus.ap_start & (~bus.out_valid | bus.out_ready)}};
            chk("in_ready", DW'(bus.in_ready), DW'(er));
            chk("grant_onehot", DW'($onehot0(bus.grant)), DW'(1));
            if (!prev_ap) chk("grant_hold", DW'(bus.grant), DW'(prev_g));
            if (prev_g == 4'b0000 && bus.grant != 4'b0000) begin
                if (gexp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_extra: got %b want none", bus.grant);
                end else begin
                    chk("grant_order", DW'(bus.grant), DW'(gexp.pop_front()));
                end
            end
            if (prev_ov && !prev_or) begin
                chk("stall_valid", DW'(bus.out_valid), DW'(1));
                chk("stall_data", bus.out_data, prev_d);
                chk("stall_last", DW'(bus.out_last), DW'(prev_l));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_extra: got %h want none", bus.out_data);
                end else begin
                    mon_b = exq.pop_front();
                    chk("beat_data", bus.out_data, mon_b.d);
                    chk("beat_last", DW'(bus.out_last), DW'(mon_b.l));
                end
            end
            prev_g  = bus.grant;
            prev_ap = bus.ap_start;
            prev_ov = bus.out_valid;
            prev_or = bus.out_ready;
            prev_l  = bus.out_last;
            prev_d  = bus.out_data;
        end
    end

    initial begin
        reset         = 1'b0;
        bus.ap_start  = 1'b0;
        bus.out_ready = 1'b0;
        #1 reset = 1'b1;
        #2 check_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        bus.ap_start  = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // all four ports with 2-beat packets
        for (int i = 0; i < 4; i++) begin
            send(i, i * 16, 1'b0, 0);
            send(i, i * 16 + 1, 1'b1, 0);
            gexp.push_back(4'b0001 << i);
            expb(i * 16, 1'b0);
            expb(i * 16 + 1, 1'b1);
        end
        drain("rr4");

        // port 2 locked while port 0 requests; port 2 gaps mid-packet
        send(2, 'hA, 1'b0, 0);
        send(2, 'hB, 1'b0, 2);
        send(2, 'hC, 1'b1, 0);
        gexp.push_back(4'b0100);
        gexp.push_back(4'b0001);
        expb('hA, 1'b0);
        expb('hB, 1'b0);
        expb('hC, 1'b1);
        expb('hD, 1'b0);
        expb('hE, 1'b1);
        wait_grant(4'b0100);
        send(0, 'hD, 1'b0, 0);
        send(0, 'hE, 1'b1, 0);
        drain("lock");

        // downstream stall for 5 cycles
        for (int k = 0; k < 4; k++) begin
            send(1, 'h20 + k, k == 3, 0);
            expb('h20 + k, k == 3);
        end
        gexp.push_back(4'b0010);
        wait_ov("stall");
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        drain("stall");

        // ap_start low for 3 cycles mid-packet
        for (int k = 0; k < 4; k++) begin
            send(3, 'h30 + k, k == 3, 0);
            expb('h30 + k, k == 3);
        end
        gexp.push_back(4'b1000);
        wait_ov("apstart");
        bus.ap_start = 1'b0;
        repeat (3) tick();
        chk("ap_drained", DW'(bus.out_valid), DW'(0));
        chk("ap_grant", DW'(bus.grant), DW'(4'b1000));
        bus.ap_start = 1'b1;
        drain("apstart");

        // single-beat packet, then reset while locked and full
        send(0, 'h50, 1'b1, 0);
        expb('h50, 1'b1);
        gexp.push_back(4'b0001);
        drain("single");
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(1, 'h60 + k, k == 3, 0);
        gexp.push_back(4'b0010);
        wait_ov("prereset");
        tick();
        tick();
        #2 reset = 1'b1;
        #1 check_zero("midreset");
        clear_all();
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        send(0, 'h70, 1'b1, 0);
        send(1, 'h71, 1'b1, 0);
        gexp.push_back(4'b0001);
        gexp.push_back(4'b0010);
        expb('h70, 1'b1);
        expb('h71, 1'b1);
        drain("postreset");

        // 17-beat packet on port 1 from a clean reset
        tick();
        #2 reset = 1'b1;
        #1 check_zero("reset2");
        clear_all();
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 17; k++) begin
            send(1, 'h80 + k, k == 16, 0);
            expb('h80 + k, k == 16);
        end
        gexp.push_back(4'b0010);
        wait_ov("burst");
        begin
            int n = 0;
            repeat (17) begin
                @(negedge clk);
                if (bus.out_valid) n++;
            end
            chk("throughput", DW'(n), DW'(17));
        end
        drain("burst");
`ifdef PE_ARB_BEAT_CNT_EN
        chk("beat_cnt", DW'(bus.beat_cnt), DW'(16'h0010));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
